cci_mpf_stat_counters: RTL and testbench

Parametrised bank of event statistics counters for MPF shims. It replaces per-shim hard-wired 64-bit CSR outputs (hit, miss, read, write and conflict counts) with NUM_COUNTERS generic counters. The counters are readable over a tagged, flow-control-free CSR read port, writable (load/clear) over a CSR write port, and support an atomic snapshot. It sits between the shims' event pulses and the MPF CSR manager.

---
 rtl/cci_mpf_stat_pkg.sv | 17 +
 rtl/cci_mpf_stat_counter.sv | 50 +++++
 rtl/cci_mpf_stat_counters.sv | 106 ++++++++++
 tb/tb_cci_mpf_stat_counters.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_stat_pkg.sv
// Shared types and constants for the MPF statistics counter bank.
package cci_mpf_stat_pkg;

    typedef logic [5:0]  t_cci_mpf_stat_idx;
    typedef logic [63:0] t_cci_mpf_stat_value;

    localparam int CCI_MPF_STAT_RD_LATENCY = 2;

    // Standard channel assignments used by the shims
    localparam t_cci_mpf_stat_idx VTP_HITS         = 6'd0;
    localparam t_cci_mpf_stat_idx VTP_MISSES       = 6'd1;
    localparam t_cci_mpf_stat_idx WRO_WRITES       = 6'd2;
    localparam t_cci_mpf_stat_idx WRO_READS        = 6'd3;
    localparam t_cci_mpf_stat_idx WRO_WR_CONFLICTS = 6'd4;
    localparam t_cci_mpf_stat_idx WRO_RD_CONFLICTS = 6'd5;

endpackage

// File: rtl/cci_mpf_stat_counter.sv
// One live/shadow statistics counter pair with increment, load and snapshot.
// Define CCI_MPF_STAT_SATURATE_EN to saturate instead of wrapping.
module cci_mpf_stat_counter #(
    parameter int unsigned COUNTER_WIDTH = 48,
    parameter int unsigned INC_WIDTH     = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [INC_WIDTH-1:0]     inc_i,
    input  logic                     load_i,
    input  logic [COUNTER_WIDTH-1:0] load_val_i,
    input  logic                     snap_i,
    output logic [COUNTER_WIDTH-1:0] live_o,
    output logic [COUNTER_WIDTH-1:0] shadow_o
);

    logic [COUNTER_WIDTH-1:0] live_q, live_d;
    logic [COUNTER_WIDTH-1:0] shadow_q, shadow_d;
`ifdef CCI_MPF_STAT_SATURATE_EN
    logic [COUNTER_WIDTH:0]   sum;
`endif

    always_comb begin
        // Snapshot captures the pre-update value; same-cycle events stay in live.
        shadow_d = snap_i ? live_q : shadow_q;
`ifdef CCI_MPF_STAT_SATURATE_EN
        sum    = {1'b0, live_q} + (COUNTER_WIDTH+1)'(inc_i);
        live_d = sum[COUNTER_WIDTH] ? '1 : sum[COUNTER_WIDTH-1:0];
`else
        live_d = live_q + COUNTER_WIDTH'(inc_i);
`endif
        if (load_i) begin
            live_d = load_val_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            live_q   <= '0;
            shadow_q <= '0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign live_o   = live_q;
    assign shadow_o = shadow_q;

endmodule

// File: rtl/cci_mpf_stat_counters.sv
// Bank of NUM_COUNTERS event counters with CSR load/snapshot and a 2-cycle read port.
// Define CCI_MPF_STAT_SATURATE_EN to make every counter saturate.
module cci_mpf_stat_counters
    import cci_mpf_stat_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS  = 8,
    parameter int unsigned COUNTER_WIDTH = 48,
    parameter int unsigned INC_WIDTH     = 2,
    parameter int unsigned TID_WIDTH     = 9
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_COUNTERS*INC_WIDTH-1:0] evt_inc,
    input  logic                              csr_wr_en,
    input  t_cci_mpf_stat_idx                 csr_wr_idx,
    input  t_cci_mpf_stat_value               csr_wr_data,
    input  logic                              csr_snap,
    input  logic                              csr_rd_en,
    input  t_cci_mpf_stat_idx                 csr_rd_idx,
    input  logic                              csr_rd_shadow,
    input  logic [TID_WIDTH-1:0]              csr_rd_tid,
    output logic                              csr_rd_rsp_valid,
    output t_cci_mpf_stat_value               csr_rd_rsp_data,
    output logic [TID_WIDTH-1:0]              csr_rd_rsp_tid
);

    logic [COUNTER_WIDTH-1:0] live   [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] shadow [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] load_val;

    assign load_val = csr_wr_data[COUNTER_WIDTH-1:0];

    if (COUNTER_WIDTH < 64) begin : g_wr_hi
        logic unused_wr_hi;
        assign unused_wr_hi = ^csr_wr_data[63:COUNTER_WIDTH];
    end

    // Indices >= NUM_COUNTERS never match a channel, so such loads are dropped.
    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ctr
        cci_mpf_stat_counter #(
            .COUNTER_WIDTH(COUNTER_WIDTH),
            .INC_WIDTH    (INC_WIDTH)
        ) u_ctr (
            .clk_i     (clk),
            .reset_n_i (reset_n),
            .inc_i     (evt_inc[i*INC_WIDTH +: INC_WIDTH]),
            .load_i    (csr_wr_en && (csr_wr_idx == t_cci_mpf_stat_idx'(i))),
            .load_val_i(load_val),
            .snap_i    (csr_snap),
            .live_o    (live[i]),
            .shadow_o  (shadow[i])
        );
    end

    logic                   s1_valid_q;
    t_cci_mpf_stat_idx      s1_idx_q;
    logic                   s1_shadow_q;
    logic [TID_WIDTH-1:0]   s1_tid_q;
    logic                   rsp_valid_q;
    t_cci_mpf_stat_value    rsp_data_q, rsp_data_d;
    logic [TID_WIDTH-1:0]   rsp_tid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_shadow_q <= 1'b0;
            s1_tid_q    <= '0;
        end else begin
            s1_valid_q  <= csr_rd_en;
            s1_idx_q    <= csr_rd_idx;
            s1_shadow_q <= csr_rd_shadow;
            s1_tid_q    <= csr_rd_tid;
        end
    end

    // Mux in stage 2 so the value includes increments from the request cycle.
    always_comb begin
        rsp_data_d = '0;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            if (s1_idx_q == t_cci_mpf_stat_idx'(i)) begin
                rsp_data_d = s1_shadow_q ? t_cci_mpf_stat_value'(shadow[i])
                                         : t_cci_mpf_stat_value'(live[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tid_q   <= '0;
        end else begin
            rsp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_q <= rsp_data_d;
                rsp_tid_q  <= s1_tid_q;
            end
        end
    end

    assign csr_rd_rsp_valid = rsp_valid_q;
    assign csr_rd_rsp_data  = rsp_data_q;
    assign csr_rd_rsp_tid   = rsp_tid_q;

endmodule

// File: tb/tb_cci_mpf_stat_counters.sv
// Self-checking bench for cci_mpf_stat_counters (48-bit bank plus a 4-bit bank).
module tb_cci_mpf_stat_counters;
    import cci_mpf_stat_pkg::*;

    localparam int unsigned NC = 8;
    localparam int unsigned IW = 2;
    localparam int unsigned TW = 9;

`ifdef CCI_MPF_STAT_SATURATE_EN
    localparam logic [63:0] EXP_W4_CH1 = 64'd15;
    localparam logic [63:0] EXP_MAX48P1 = 64'h0000_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] EXP_W4_CH1 = 64'd2;
    localparam logic [63:0] EXP_MAX48P1 = 64'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [NC*IW-1:0]     evt_inc;
    logic                 csr_wr_en;
    logic [5:0]           csr_wr_idx;
    logic [63:0]          csr_wr_data;
    logic                 csr_snap;
    logic                 csr_rd_en;
    logic [5:0]           csr_rd_idx;
    logic                 csr_rd_shadow;
    logic [TW-1:0]        csr_rd_tid;
    logic                 rsp_valid,  rsp4_valid;
    logic [63:0]          rsp_data,   rsp4_data;
    logic [TW-1:0]        rsp_tid,    rsp4_tid;

    cci_mpf_stat_counters #(
        .NUM_COUNTERS(NC), .COUNTER_WIDTH(48), .INC_WIDTH(IW), .TID_WIDTH(TW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .evt_inc(evt_inc),
        .csr_wr_en(csr_wr_en), .csr_wr_idx(csr_wr_idx), .csr_wr_data(csr_wr_data),
        .csr_snap(csr_snap), .csr_rd_en(csr_rd_en), .csr_rd_idx(csr_rd_idx),
        .csr_rd_shadow(csr_rd_shadow), .csr_rd_tid(csr_rd_tid),
        .csr_rd_rsp_valid(rsp_valid), .csr_rd_rsp_data(rsp_data), .csr_rd_rsp_tid(rsp_tid)
    );

    cci_mpf_stat_counters #(
        .NUM_COUNTERS(NC), .COUNTER_WIDTH(4), .INC_WIDTH(IW), .TID_WIDTH(TW)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .evt_inc(evt_inc),
        .csr_wr_en(csr_wr_en), .csr_wr_idx(csr_wr_idx), .csr_wr_data(csr_wr_data),
        .csr_snap(csr_snap), .csr_rd_en(csr_rd_en), .csr_rd_idx(csr_rd_idx),
        .csr_rd_shadow(csr_rd_shadow), .csr_rd_tid(csr_rd_tid),
        .csr_rd_rsp_valid(rsp4_valid), .csr_rd_rsp_data(rsp4_data), .csr_rd_rsp_tid(rsp4_tid)
    );

    typedef struct {
        logic [63:0]  data;
        logic [TW-1:0] tid;
        int unsigned  cyc;
        bit           chk4;
        logic [63:0]  data4;
    } sb_t;

    sb_t         sbq[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every valid response must match the head of the scoreboard.
    always @(negedge clk) begin
        sb_t e;
        if (rsp_valid !== 1'b0) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_tid", 64'(rsp_tid), 64'(e.tid));
                check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk4) begin
                    check("rsp4_valid", 64'(rsp4_valid), 64'd1);
                    check("rsp4_data", rsp4_data, e.data4);
                    check("rsp4_tid", 64'(rsp4_tid), 64'(e.tid));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        csr_rd_en = 1'b0;
        csr_wr_en = 1'b0;
        csr_snap  = 1'b0;
    endtask

    task automatic req(input logic [5:0] idx, input logic sh, input logic [TW-1:0] tid,
                       input logic [63:0] exp, input bit chk4 = 1'b0,
                       input logic [63:0] exp4 = 64'd0);
        sb_t e;
        csr_rd_en = 1'b1; csr_rd_idx = idx; csr_rd_shadow = sh; csr_rd_tid = tid;
        e.data = exp; e.tid = tid; e.cyc = cyc + CCI_MPF_STAT_RD_LATENCY;
        e.chk4 = chk4; e.data4 = exp4;
        sbq.push_back(e);
    endtask

    task automatic load(input logic [5:0] idx, input logic [63:0] val);
        csr_wr_en = 1'b1; csr_wr_idx = idx; csr_wr_data = val;
    endtask

    task automatic set_inc(input int ch, input logic [IW-1:0] v);
        evt_inc[ch*IW +: IW] = v;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    task automatic do_reset();
        evt_inc = '0;
        reset_n = 1'b0;
        step();
        step();
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_tid", 64'(rsp_tid), 64'd0);
        reset_n = 1'b1;
        step();
    endtask

    typedef struct {
        int          ch;
        logic [IW-1:0] inc;
        int          n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int nv;
        vecs[0] = '{int'(VTP_HITS),         2'd1, 10, 64'd10};
        vecs[1] = '{int'(WRO_READS),        2'd3,  4, 64'd12};
        vecs[2] = '{int'(WRO_RD_CONFLICTS), 2'd2,  7, 64'd14};
        vecs[3] = '{7,                      2'd0,  5, 64'd0};

        reset_n = 1'b0; evt_inc = '0; csr_wr_en = 1'b0; csr_wr_idx = '0; csr_wr_data = '0;
        csr_snap = 1'b0; csr_rd_en = 1'b0; csr_rd_idx = '0; csr_rd_shadow = 1'b0; csr_rd_tid = '0;

        // Table-driven single-channel counting
        for (int k = 0; k < 4; k++) begin
            do_reset();
            set_inc(vecs[k].ch, vecs[k].inc);
            repeat (vecs[k].n) step();
            evt_inc = '0;
            req(6'(vecs[k].ch), 1'b0, TW'(9'h100 + k), vecs[k].exp);
            step();
            drain();
        end

        // Overlapping channels 0 and 3, back-to-back reads
        do_reset();
        set_inc(0, 2'd1); set_inc(3, 2'd3);
        repeat (4) step();
        set_inc(3, 2'd0);
        repeat (6) step();
        evt_inc = '0;
        req(VTP_HITS, 1'b0, 9'h011, 64'd10); step();
        req(WRO_READS, 1'b0, 9'h013, 64'd12); step();
        drain();

        // Narrow bank wrap/saturate
        do_reset();
        set_inc(1, 2'd3);
        repeat (6) step();
        evt_inc = '0;
        req(VTP_MISSES, 1'b0, 9'h021, 64'd18, 1'b1, EXP_W4_CH1); step();
        drain();

        // Load vs same-cycle increment, read includes request-cycle increment
        do_reset();
        load(WRO_WRITES, 64'h100); set_inc(2, 2'd1); step();
        set_inc(2, 2'd0);
        req(WRO_WRITES, 1'b0, 9'h031, 64'h100); step();
        set_inc(2, 2'd1);
        req(WRO_WRITES, 1'b0, 9'h032, 64'h101); step();
        evt_inc = '0;
        drain();
        step();
        check("hold_valid", 64'(rsp_valid), 64'd0);
        check("hold_data", rsp_data, 64'h101);
        load(6, '1); step();
        req(6, 1'b0, 9'h033, 64'h0000_FFFF_FFFF_FFFF); step();
        drain();
        load(WRO_WR_CONFLICTS, '1); step();
        set_inc(4, 2'd1); step();
        evt_inc = '0;
        req(WRO_WR_CONFLICTS, 1'b0, 9'h034, EXP_MAX48P1); step();
        drain();

        // Snapshot
        do_reset();
        set_inc(0, 2'd1);
        repeat (5) step();
        csr_snap = 1'b1; step();
        repeat (6) step();
        evt_inc = '0;
        req(VTP_HITS, 1'b1, 9'h041, 64'd5); step();
        req(VTP_HITS, 1'b0, 9'h042, 64'd12); step();
        drain();
        load(VTP_MISSES, 64'd9); step();
        csr_snap = 1'b1; load(VTP_MISSES, 64'h55); step();
        req(VTP_MISSES, 1'b1, 9'h043, 64'd9); step();
        req(VTP_MISSES, 1'b0, 9'h044, 64'h55); step();
        req(VTP_HITS, 1'b1, 9'h045, 64'd12); step();
        drain();

        // Back-to-back reads including out-of-range index; out-of-range load ignored
        do_reset();
        for (int i = 0; i < 8; i++) begin
            load(6'(i), 64'(i * 16 + 1)); step();
        end
        load(6'd40, 64'hDEAD); step();
        for (int t = 0; t < 8; t++) begin
            if (t == 4) req(6'd63, 1'b0, TW'(t), 64'd0);
            else        req(6'(t), 1'b0, TW'(t), 64'(t * 16 + 1));
            step();
        end
        drain();

        // Reset with a read in flight
        load(0, 64'd7); step();
        load(3, 64'd9); step();
        csr_rd_en = 1'b1; csr_rd_idx = 6'd0; csr_rd_shadow = 1'b0; csr_rd_tid = 9'h1AA;
        step();
        reset_n = 1'b0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) nv++;
        end
        check("rst_no_rsp", 64'(nv), 64'd0);
        check("rst_mid_data", rsp_data, 64'd0);
        check("rst_mid_tid", 64'(rsp_tid), 64'd0);
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            req(6'(i), 1'b0, TW'(9'h080 + i), 64'd0); step();
        end
        req(6'd3, 1'b1, 9'h090, 64'd0); step();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
